// File: rtl/cmd_saver.sv
// Serialises a RAM region into TRS-80 /CMD records (load blocks, then a transfer block or EOF).
// RAM is read through a single-outstanding read port; bytes leave on a valid/ready stream.
module cmd_saver #(
  parameter int ADDR   = 16,
  parameter int RD_LAT = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [ADDR-1:0] start_addr,
  input  logic [ADDR-1:0] end_addr,
  input  logic [ADDR-1:0] exec_addr,
  input  logic            exec_en,
  input  logic            abort,
  output logic [ADDR-1:0] mem_addr,
  output logic            mem_rd,
  input  logic [7:0]      mem_din,
  output logic [7:0]      out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic [23:0]     out_offset,
  output logic            busy,
  output logic            done,
  output logic            error
);

  typedef enum logic [3:0] {
    S_IDLE, S_B_TYPE, S_B_LEN, S_B_LSB, S_B_MSB, S_RD_REQ, S_RD_WAIT,
    S_DATA, S_X_TYPE, S_X_LEN, S_X_LSB, S_X_MSB, S_EOF
  } state_t;

  state_t          state_q;
  logic [ADDR-1:0] cur_q;
  logic [ADDR-1:0] exec_q;
  logic            exec_en_q;
  logic [ADDR:0]   rem_q;
  logic [8:0]      chunk_q;
  logic [2:0]      lat_q;
  logic [7:0]      data_q;
  logic            valid_q;
  logic            last_q;
  logic [23:0]     off_q;
  logic            busy_q;
  logic            done_q;
  logic            error_q;
  logic            rd_q;
  logic [ADDR-1:0] addr_q;

  logic            accept;
  logic [16:0]     rem_w;
  logic [8:0]      chunk_n;
  logic [7:0]      len_byte;
  logic [15:0]     cur_w;
  logic [15:0]     exec_w;
  logic [ADDR-1:0] cur_inc;

  always_comb begin
    accept   = valid_q & out_ready;
    rem_w    = 17'(rem_q);
    chunk_n  = (rem_w > 17'd256) ? 9'd256 : rem_w[8:0];
    // (n+2) mod 256: a 256-byte block encodes as 02
    len_byte = chunk_n[7:0] + 8'd2;
    cur_w    = 16'(cur_q);
    exec_w   = 16'(exec_q);
    cur_inc  = cur_q + ADDR'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cur_q     <= '0;
      exec_q    <= '0;
      exec_en_q <= 1'b0;
      rem_q     <= '0;
      chunk_q   <= '0;
      lat_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      off_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      rd_q      <= 1'b0;
      addr_q    <= '0;
    end else begin
      done_q <= 1'b0;
      rd_q   <= 1'b0;
      if (abort) begin
        state_q <= S_IDLE;
        valid_q <= 1'b0;
        last_q  <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        if (accept) off_q <= off_q + 24'd1;
        case (state_q)
          S_IDLE: begin
            if (start) begin
              off_q     <= '0;
              error_q   <= 1'b0;
              exec_q    <= exec_addr;
              exec_en_q <= exec_en;
              cur_q     <= start_addr;
              rem_q     <= {1'b0, end_addr} - {1'b0, start_addr} + (ADDR+1)'(1);
              if (end_addr < start_addr) begin
                error_q <= 1'b1;
                done_q  <= 1'b1;
              end else begin
                busy_q  <= 1'b1;
                data_q  <= 8'h01;
                valid_q <= 1'b1;
                state_q <= S_B_TYPE;
              end
            end
          end
          S_B_TYPE: if (accept) begin
            data_q  <= len_byte;
            chunk_q <= chunk_n;
            state_q <= S_B_LEN;
          end
          S_B_LEN: if (accept) begin
            data_q  <= cur_w[7:0];
            state_q <= S_B_LSB;
          end
          S_B_LSB: if (accept) begin
            data_q  <= cur_w[15:8];
            state_q <= S_B_MSB;
          end
          S_B_MSB: if (accept) begin
            valid_q <= 1'b0;
            rd_q    <= 1'b1;
            addr_q  <= cur_q;
            state_q <= S_RD_REQ;
          end
          S_RD_REQ: begin
            lat_q   <= 3'd1;
            state_q <= S_RD_WAIT;
          end
          S_RD_WAIT: begin
            if (lat_q == 3'(RD_LAT)) begin
              data_q  <= mem_din;
              valid_q <= 1'b1;
              state_q <= S_DATA;
            end else begin
              lat_q <= lat_q + 3'd1;
            end
          end
          S_DATA: if (accept) begin
            cur_q   <= cur_inc;
            rem_q   <= rem_q - (ADDR+1)'(1);
            chunk_q <= chunk_q - 9'd1;
            if (chunk_q != 9'd1) begin
              valid_q <= 1'b0;
              rd_q    <= 1'b1;
              addr_q  <= cur_inc;
              state_q <= S_RD_REQ;
            end else if (rem_q != (ADDR+1)'(1)) begin
              data_q  <= 8'h01;
              state_q <= S_B_TYPE;
            end else if (exec_en_q) begin
              data_q  <= 8'h02;
              state_q <= S_X_TYPE;
            end else begin
              data_q  <= 8'h00;
              last_q  <= 1'b1;
              state_q <= S_EOF;
            end
          end
          S_X_TYPE: if (accept) begin
            data_q  <= 8'h02;
            state_q <= S_X_LEN;
          end
          S_X_LEN: if (accept) begin
            data_q  <= exec_w[7:0];
            state_q <= S_X_LSB;
          end
          S_X_LSB: if (accept) begin
            data_q  <= exec_w[15:8];
            last_q  <= 1'b1;
            state_q <= S_X_MSB;
          end
          S_X_MSB, S_EOF: if (accept) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign mem_addr   = addr_q;
  assign mem_rd     = rd_q;
  assign out_data   = data_q;
  assign out_valid  = valid_q;
  assign out_last   = last_q;
  assign out_offset = off_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_cmd_saver.sv
// Scoreboard bench for cmd_saver: expected bytes are queued at stimulus time and
// popped by an independent monitor on every accepted stream byte.
module tb_cmd_saver;
  localparam int ADDR   = 16;
  localparam int RD_LAT = 3;

  logic        clock = 1'b0;
  logic        reset, start, exec_en, abort;
  logic [15:0] start_addr, end_addr, exec_addr, mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_din, out_data;
  logic        out_valid, out_ready, out_last, busy, done, error;
  logic [23:0] out_offset;

  always #5 clock = ~clock;

  cmd_saver #(.ADDR(ADDR), .RD_LAT(RD_LAT)) dut (
    .clock(clock), .reset(reset), .start(start),
    .start_addr(start_addr), .end_addr(end_addr), .exec_addr(exec_addr),
    .exec_en(exec_en), .abort(abort),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_din(mem_din),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_offset(out_offset),
    .busy(busy), .done(done), .error(error)
  );

  // RAM with RD_LAT pipeline; E7 (never stored in RAM) appears when no read is due
  logic [7:0] ram [0:65535];
  logic [7:0] pipe [RD_LAT];
  always @(posedge clock) begin
    pipe[0] <= mem_rd ? ram[mem_addr] : 8'hE7;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_din = pipe[RD_LAT-1];

  typedef struct {
    logic [7:0]  d;
    logic        l;
    logic [23:0] o;
    logic        isd;
  } exp_t;

  exp_t        q[$];
  exp_t        me;
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          acc_cnt = 0;
  int unsigned exp_off = 0;
  logic        rnd = 1'b0;

  logic        hold_v = 1'b0;
  logic [7:0]  hold_d;
  logic        hold_l;
  logic [23:0] hold_o;
  logic        rd_pend = 1'b0;

  always @(negedge clock) begin
    if (reset) begin
      hold_v  = 1'b0;
      rd_pend = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (mem_rd) begin
        checks++;
        if (rd_pend) begin
          errors++;
          $display("FAIL rd_overlap mem_rd=1 while read/data pending at t=%0t, required 0", $time);
        end
        rd_pend = 1'b1;
      end
      if (hold_v) begin
        checks++;
        if (!out_valid || out_data !== hold_d || out_last !== hold_l || out_offset !== hold_o) begin
          errors++;
          $display("FAIL stable got v=%b d=%h l=%b o=%0d, required v=1 d=%h l=%b o=%0d",
                   out_valid, out_data, out_last, out_offset, hold_d, hold_l, hold_o);
        end
      end
      if (out_valid && out_ready) begin
        acc_cnt++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte got d=%h o=%0d, required no byte", out_data, out_offset);
        end else begin
          me = q.pop_front();
          if (out_data !== me.d || out_last !== me.l || out_offset !== me.o) begin
            errors++;
            $display("FAIL byte got d=%h l=%b o=%0d, required d=%h l=%b o=%0d",
                     out_data, out_last, out_offset, me.d, me.l, me.o);
          end
          if (me.isd) rd_pend = 1'b0;
        end
      end
      hold_v = out_valid && !out_ready && !abort;
      hold_d = out_data;
      hold_l = out_last;
      hold_o = out_offset;
      if (abort) rd_pend = 1'b0;
    end
  end

  always begin
    @(posedge clock);
    #1;
    if (rnd) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data"},   32'(out_data),   32'd0);
    chk({tag, "_valid"},  32'(out_valid),  32'd0);
    chk({tag, "_last"},   32'(out_last),   32'd0);
    chk({tag, "_offset"}, 32'(out_offset), 32'd0);
    chk({tag, "_busy"},   32'(busy),       32'd0);
    chk({tag, "_done"},   32'(done),       32'd0);
    chk({tag, "_error"},  32'(error),      32'd0);
    chk({tag, "_mem_rd"}, 32'(mem_rd),     32'd0);
    chk({tag, "_addr"},   32'(mem_addr),   32'd0);
  endtask

  task automatic push(input logic [7:0] d, input logic l, input logic isd);
    q.push_back('{d, l, 24'(exp_off), isd});
    exp_off++;
  endtask

  task automatic push_file(input logic [15:0] s, input logic [15:0] e,
                           input logic [15:0] x, input logic en);
    int unsigned rem;
    int unsigned n;
    logic [15:0] cur;
    logic [7:0]  lb;
    rem = 32'(e) - 32'(s) + 1;
    cur = s;
    while (rem > 0) begin
      n  = (rem > 256) ? 256 : rem;
      lb = 8'(n + 2);
      push(8'h01, 1'b0, 1'b0);
      push(lb, 1'b0, 1'b0);
      push(cur[7:0], 1'b0, 1'b0);
      push(cur[15:8], 1'b0, 1'b0);
      for (int unsigned i = 0; i < n; i++) begin
        push(ram[cur], 1'b0, 1'b1);
        cur++;
        rem--;
      end
    end
    if (en) begin
      push(8'h02, 1'b0, 1'b0);
      push(8'h02, 1'b0, 1'b0);
      push(x[7:0], 1'b0, 1'b0);
      push(x[15:8], 1'b1, 1'b0);
    end else begin
      push(8'h00, 1'b1, 1'b0);
    end
  endtask

  task automatic go(input logic [15:0] s, input logic [15:0] e,
                    input logic [15:0] x, input logic en);
    @(posedge clock);
    #1;
    start_addr = s;
    end_addr   = e;
    exec_addr  = x;
    exec_en    = en;
    start      = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic finish_run(input string name, input int budget, input int nbytes, input int acc0);
    int d0;
    int k;
    d0 = done_cnt;
    k  = 0;
    while (done_cnt == d0 && k < budget) begin
      @(posedge clock);
      k++;
    end
    chk({name, "_done_seen"}, 32'(done_cnt), 32'(d0 + 1));
    repeat (3) @(posedge clock);
    #1;
    chk({name, "_done_once"}, 32'(done_cnt), 32'(d0 + 1));
    chk({name, "_bytes"},     32'(acc_cnt - acc0), 32'(nbytes));
    chk({name, "_q_empty"},   32'(q.size()), 32'd0);
    chk({name, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int acc0;
    int k;
    for (int i = 0; i < 65536; i++) ram[i] = 8'((i * 7 + 3) & 127);
    ram[16'h5200] = 8'hAA;
    ram[16'h5201] = 8'hBB;
    ram[16'h5202] = 8'hCC;

    reset = 1'b1; start = 1'b0; abort = 1'b0; exec_en = 1'b0; out_ready = 1'b1;
    start_addr = '0; end_addr = '0; exec_addr = '0;
    repeat (3) @(negedge clock);
    chk_zero("reset");
    @(posedge clock);
    #1 reset = 1'b0;

    // three bytes with transfer block, hand-computed stream
    exp_off = 0;
    push(8'h01, 1'b0, 1'b0); push(8'h05, 1'b0, 1'b0); push(8'h00, 1'b0, 1'b0); push(8'h52, 1'b0, 1'b0);
    push(8'hAA, 1'b0, 1'b1); push(8'hBB, 1'b0, 1'b1); push(8'hCC, 1'b0, 1'b1);
    push(8'h02, 1'b0, 1'b0); push(8'h02, 1'b0, 1'b0); push(8'h00, 1'b0, 1'b0); push(8'h52, 1'b1, 1'b0);
    acc0 = acc_cnt;
    go(16'h5200, 16'h5202, 16'h5200, 1'b1);
    @(negedge clock);
    chk("t1_busy", 32'(busy), 32'd1);
    finish_run("t1", 500, 11, acc0);

    // full 256-byte block, EOF ending
    exp_off = 0;
    push_file(16'h6000, 16'h60FF, 16'h0000, 1'b0);
    acc0 = acc_cnt;
    go(16'h6000, 16'h60FF, 16'h0000, 1'b0);
    finish_run("t2", 4000, 261, acc0);

    // 257 bytes: second block header 01 03 00 61
    exp_off = 0;
    push_file(16'h6000, 16'h6100, 16'h0000, 1'b0);
    chk("t3_hdr2_len", 32'(q[261].d), 32'h03);
    chk("t3_hdr2_msb", 32'(q[263].d), 32'h61);
    acc0 = acc_cnt;
    go(16'h6000, 16'h6100, 16'h0000, 1'b0);
    finish_run("t3", 4000, 266, acc0);

    // random back-pressure
    exp_off = 0;
    push_file(16'h6000, 16'h6100, 16'h1234, 1'b1);
    acc0 = acc_cnt;
    rnd = 1'b1;
    go(16'h6000, 16'h6100, 16'h1234, 1'b1);
    finish_run("t4", 10000, 269, acc0);
    rnd = 1'b0;
    @(posedge clock);
    #1 out_ready = 1'b1;

    // reversed range: error + done, no bytes; next valid start clears error
    acc0 = acc_cnt;
    go(16'h7000, 16'h6FFF, 16'h0000, 1'b0);
    finish_run("t5", 20, 0, acc0);
    chk("t5_error", 32'(error), 32'd1);
    exp_off = 0;
    push(8'h01, 1'b0, 1'b0); push(8'h05, 1'b0, 1'b0); push(8'h00, 1'b0, 1'b0); push(8'h52, 1'b0, 1'b0);
    push(8'hAA, 1'b0, 1'b1); push(8'hBB, 1'b0, 1'b1); push(8'hCC, 1'b0, 1'b1);
    push(8'h00, 1'b1, 1'b0);
    acc0 = acc_cnt;
    go(16'h5200, 16'h5202, 16'h0000, 1'b0);
    @(negedge clock);
    chk("t6_error_clr", 32'(error), 32'd0);
    finish_run("t6", 500, 8, acc0);

    // abort mid-data
    exp_off = 0;
    push_file(16'h6000, 16'h60FF, 16'h0000, 1'b0);
    acc0 = acc_cnt;
    go(16'h6000, 16'h60FF, 16'h0000, 1'b0);
    k = 0;
    while (acc_cnt < acc0 + 12 && k < 500) begin
      @(posedge clock);
      k++;
    end
    chk("abort_progress", 32'(acc_cnt >= acc0 + 12), 32'd1);
    #1 out_ready = 1'b0;
    @(posedge clock);
    #1 abort = 1'b1;
    @(posedge clock);
    #1 abort = 1'b0;
    k = done_cnt;
    @(negedge clock);
    chk("abort_valid",  32'(out_valid), 32'd0);
    chk("abort_busy",   32'(busy),      32'd0);
    chk("abort_mem_rd", 32'(mem_rd),    32'd0);
    chk("abort_error",  32'(error),     32'd0);
    q.delete();
    repeat (4) @(posedge clock);
    chk("abort_no_done", 32'(done_cnt), 32'(k));

    // reset while holding in B_LEN
    exp_off = 0;
    push(8'h01, 1'b0, 1'b0);
    go(16'h6000, 16'h60FF, 16'h0000, 1'b0);
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clock);
      k++;
    end
    chk("rst_b_type_valid", 32'(out_valid), 32'd1);
    @(posedge clock);
    #1 out_ready = 1'b1;
    @(posedge clock);
    #1 out_ready = 1'b0;
    chk("rst_pre_offset", 32'(out_offset), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk_zero("mid_reset");
    q.delete();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    out_ready = 1'b1;

    // complete file after reset, from offset 0
    exp_off = 0;
    push(8'h01, 1'b0, 1'b0); push(8'h05, 1'b0, 1'b0); push(8'h00, 1'b0, 1'b0); push(8'h52, 1'b0, 1'b0);
    push(8'hAA, 1'b0, 1'b1); push(8'hBB, 1'b0, 1'b1); push(8'hCC, 1'b0, 1'b1);
    push(8'h02, 1'b0, 1'b0); push(8'h02, 1'b0, 1'b0); push(8'h34, 1'b0, 1'b0); push(8'h12, 1'b1, 1'b0);
    acc0 = acc_cnt;
    go(16'h5200, 16'h5202, 16'h1234, 1'b1);
    finish_run("t7", 500, 11, acc0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmd_saver.md
Name: cmd_saver

Overview:
- Serialises a RAM region into TRS-80 /CMD byte format for upload to the HPS; this is the write-back side of the /CMD load path.
- Reads emulated RAM through a simple read port and emits a byte stream using a valid/ready handshake with a running file offset.
- Sits between the RAM arbiter (shared read port) and the ioctl upload glue.

Parameters:
- ADDR, 16, RAM address width.
- RD_LAT, 1, cycles from mem_rd pulse to valid mem_din (1..4).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle pulse; latches start_addr/end_addr/exec_addr/exec_en; ignored when busy=1
- start_addr  in  ADDR  first byte to save
- end_addr  in  ADDR  last byte to save (inclusive)
- exec_addr  in  ADDR  entry point for transfer block
- exec_en  in  1  1: finish with transfer block (type 02); 0: finish with EOF byte 00
- abort  in  1  level; forces return to IDLE
- mem_addr  out  ADDR  RAM read address
- mem_rd  out  1  one-cycle read strobe
- mem_din  in  8  RAM read data, valid RD_LAT cycles after mem_rd
- out_data  out  8  stream byte
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts byte when out_valid&out_ready
- out_last  out  1  marks final byte of file, qualified by out_valid
- out_offset  out  24  file offset of current out_data
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse after final byte accepted
- error  out  1  sticky until next start; set when end_addr<start_addr

Behaviour:
- Reset: every output is 0, and the state is IDLE.
- Byte acceptance: a byte is accepted on a cycle with out_valid&out_ready. out_data, out_last and out_offset stay stable while out_valid=1 and out_ready=0. out_offset increments by 1 after each accepted byte and is cleared on start.
- start in IDLE:
  - Latch all inputs and clear error.
  - remaining = end_addr-start_addr+1, computed ADDR+1 bits wide (full space = 2^ADDR).
  - cur = start_addr.
  - If end_addr<start_addr: set error, pulse done next cycle, emit no bytes, stay IDLE.
  - Otherwise set busy=1 and go to B_TYPE.
- States and transitions (each emit state holds one byte on out_data and advances on acceptance):
  - B_TYPE emits 01.
  - B_LEN: n=min(256,remaining); emits (n+2)&FF, so 256→02, 255→01, 254→00, 1→03.
  - B_LSB emits cur[7:0].
  - B_MSB emits cur[15:8]; upper bits are 0 when ADDR<16.
  - RD_REQ: mem_addr=cur, pulse mem_rd.
  - RD_WAIT: wait RD_LAT cycles, capture mem_din.
  - DATA: emits the captured byte. On acceptance: cur=cur+1 (mod 2^ADDR), remaining-=1, chunk count-=1. Chunk count >0 → RD_REQ. Chunk done and remaining>0 → B_TYPE. Chunk done and remaining=0 → X_TYPE if exec_en, else EOF.
  - X_TYPE/X_LEN/X_LSB/X_MSB emit 02, 02, exec_addr LSB, exec_addr MSB; out_last=1 on X_MSB.
  - EOF emits 00 with out_last=1.
  - After the last byte is accepted: done pulses 1 cycle, busy=0, go to IDLE.
- Only one read is outstanding at a time; mem_rd never fires while a DATA byte is pending.
- Throughput: RD_LAT+2 cycles minimum per data byte; header bytes take 1 cycle each when out_ready=1.
- abort (any state): next cycle IDLE, out_valid=0, busy=0, mem_rd=0; no done pulse; error unchanged.
- abort and start in the same cycle: abort wins.
- Reset mid-operation clears everything asynchronously; no partial state survives.
- Total bytes for region size S = S + 4·ceil(S/256) + (exec_en ? 4 : 1).

Test Plan:
- RAM 5200..5202=AA BB CC, start 5200, end 5202, exec 5200, exec_en=1, out_ready=1 → bytes 01 05 00 52 AA BB CC 02 02 00 52; out_last on final 52; offsets 0..10; done once.
- 256-byte region 6000..60FF, exec_en=0 → 01 02 00 60, 256 data bytes, 00 (last); 261 bytes total.
- 257-byte region 6000..6100 → second block header 01 03 00 61 followed by RAM[6100]; len bytes 02 then 03.
- Random out_ready toggling with RD_LAT=3 → identical byte sequence to the out_ready=1 run; out_data stable whenever out_valid&~out_ready; mem_rd never while DATA pending.
- start 7000, end 6FFF → error=1, done pulse, zero bytes emitted; next valid start clears error.
- abort asserted mid-data, then reset asserted during B_LEN → IDLE, all outputs 0; a subsequent start produces a complete, correct file from offset 0.
